// File: rtl/mm_dot_product_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mm_dot_product_unit
//  Brief    : Streaming signed multiply-accumulate over VEC_LEN element pairs,
//             with a saturating accumulator and a held result on a handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module mm_dot_product_unit #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int VEC_LEN = 4,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int PROD_W = 2 * DATA_W;
    // One guard bit above the wider of accumulator and product
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    localparam logic signed [SUM_W-1:0] C_SUM_MAX =
        {{(SUM_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] C_SUM_MIN =
        {{(SUM_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};
    localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0]        C_LAST    = CNT_W'(VEC_LEN - 1);

    logic [0:0]               r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_count;
    logic                     r_ovf;

    logic signed [PROD_W-1:0] w_a_ext;
    logic signed [PROD_W-1:0] w_b_ext;
    logic signed [PROD_W-1:0] w_product;
    logic signed [SUM_W-1:0]  w_acc_ext;
    logic signed [SUM_W-1:0]  w_prod_ext;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_sat;
    logic                     w_accept;
    logic                     w_release;

    assign w_a_ext    = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    assign w_b_ext    = {{DATA_W{b_in[DATA_W-1]}}, b_in};
    assign w_product  = w_a_ext * w_b_ext;
    assign w_acc_ext  = {{(SUM_W - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_prod_ext = {{(SUM_W - PROD_W){w_product[PROD_W-1]}}, w_product};
    assign w_sum      = w_acc_ext + w_prod_ext;

    always_comb begin
        w_sat      = 1'b0;
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_sum > C_SUM_MAX) begin
            w_sat      = 1'b1;
            w_acc_next = C_ACC_MAX;
        end else if (w_sum < C_SUM_MIN) begin
            w_sat      = 1'b1;
            w_acc_next = C_ACC_MIN;
        end
    end

    // in_ready is forced low for the whole time rst is asserted
    assign in_ready  = ~rst & (r_state == ST_ACCUM);
    assign w_accept  = in_valid & in_ready & ~clr;
    assign w_release = (r_state == ST_HOLD) & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr || w_release) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_ovf   <= r_ovf | w_sat;
            r_count <= r_count + 1'b1;
            if (r_count == C_LAST) begin
                r_state <= ST_HOLD;
            end
        end
    end

    // The accumulator itself is the held result while in HOLD
    assign out_valid = (r_state == ST_HOLD);
    assign result    = r_acc;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
